// File: rtl/ppt_reg_bank.sv
// ppt_reg_bank -- byte-level register file between the I2C slave and the
// pulse generator / pulse counter.
//
// Decodes START/STOP strobes and received bytes from the I2C slave (already
// in the clk domain), keeps a 3-bit auto-incrementing register pointer and
// drives the pulse generator configuration.
//
// Register map (ptr):
//   0 CTRL  : bit0 run (RW), bit1 clear (W1 pulses count_clr, reads 0),
//             bit7 err (reads sticky flag, W1 clears), other bits read 0
//   1 PER_L, 2 PER_H, 3 WID_L, 4 WID_H : RW. The low byte goes to a shadow,
//             and the high-byte write commits the 16-bit value atomically.
//   5 CNT_L, 6 CNT_H : RO, pulse count
//   7 ID    : RO, ID_VALUE
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, stop       I2C START/repeated START and STOP strobes
//   wr_valid, wr_data received byte strobe and byte
//   rd_req            request for the next byte to transmit
//   rd_data, rd_valid registered read byte, valid one cycle after rd_req
//   count             live pulse counter value
//   run               pulse generator/counter enable
//   pulse_period      committed period
//   pulse_width       committed width
//   count_clr         one-cycle pulse counter clear strobe
//   err               sticky flag: a width/period commit was rejected
//
// Configuration macro: PPT_REGS_SNAPSHOT_EN. When it is defined, a CNT_L read
// latches count[15:8] and a later CNT_H read returns that latched byte. When
// it is undefined, CNT_H returns the live count[15:8].

module ppt_reg_bank #(
  parameter logic [15:0] RST_PERIOD = 16'd10,
  parameter logic [15:0] RST_WIDTH  = 16'd2,
  parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        rd_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic [15:0] count,
  output logic        run,
  output logic [15:0] pulse_period,
  output logic [15:0] pulse_width,
  output logic        count_clr,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_PER_L = 3'd1;
  localparam logic [2:0] A_PER_H = 3'd2;
  localparam logic [2:0] A_WID_L = 3'd3;
  localparam logic [2:0] A_WID_H = 3'd4;
  localparam logic [2:0] A_CNT_L = 3'd5;
  localparam logic [2:0] A_CNT_H = 3'd6;
  localparam logic [2:0] A_ID    = 3'd7;

  state_t      state;
  logic [2:0]  ptr;
  logic [7:0]  per_shadow;
  logic [7:0]  wid_shadow;
  logic [7:0]  cnt_hi_rd;

  // The candidate values a high-byte write would commit. A period commit
  // checks against the current width, and a width commit checks against the
  // current period. The bounds stay consistent because only one half can
  // change per write.
  logic [15:0] per_cand;
  logic [15:0] wid_cand;
  logic        per_ok;
  logic        wid_ok;

  assign per_cand = {wr_data, per_shadow};
  assign wid_cand = {wr_data, wid_shadow};
  assign per_ok   = (per_cand != 16'd0) && (pulse_width < per_cand);
  assign wid_ok   = (pulse_period != 16'd0) && (wid_cand < pulse_period);

`ifdef PPT_REGS_SNAPSHOT_EN
  logic [7:0] cnt_snap;

  assign cnt_hi_rd = cnt_snap;
`else
  assign cnt_hi_rd = count[15:8];
`endif

  // Read mux. The period and width registers return committed values, never
  // the shadows.
  function automatic logic [7:0] reg_read(input logic [2:0] a);
    logic [7:0] d;
    d = 8'h00;
    case (a)
      A_CTRL:  d = {err, 6'd0, run};
      A_PER_L: d = pulse_period[7:0];
      A_PER_H: d = pulse_period[15:8];
      A_WID_L: d = pulse_width[7:0];
      A_WID_H: d = pulse_width[15:8];
      A_CNT_L: d = count[7:0];
      A_CNT_H: d = cnt_hi_rd;
      A_ID:    d = ID_VALUE;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  // NOTE: all state is updated with non-blocking assignments, so every branch
  // below reads the pre-edge values of ptr, shadows and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 3'd0;
      per_shadow   <= 8'h00;
      wid_shadow   <= 8'h00;
      run          <= 1'b0;
      pulse_period <= RST_PERIOD;
      pulse_width  <= RST_WIDTH;
      count_clr    <= 1'b0;
      err          <= 1'b0;
      rd_data      <= 8'h00;
      rd_valid     <= 1'b0;
`ifdef PPT_REGS_SNAPSHOT_EN
      cnt_snap     <= 8'h00;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      count_clr <= 1'b0;
      rd_valid  <= 1'b0;

      // Bus framing strobes win, and a byte or read in the same cycle is dropped.
      if (start) begin
        state <= ADDR;
      end else if (stop) begin
        state <= IDLE;
      end else if (wr_valid) begin
        // A write beats a simultaneous read, and the read gets no reply.
        case (state)
          ADDR: begin
            ptr   <= wr_data[2:0];
            state <= DATA;
          end
          DATA: begin
            ptr <= ptr + 3'd1;
            case (ptr)
              A_CTRL: begin
                run       <= wr_data[0];
                count_clr <= wr_data[1];
                if (wr_data[7]) err <= 1'b0;
              end
              A_PER_L: per_shadow <= wr_data;
              A_PER_H: begin
                if (per_ok) pulse_period <= per_cand;
                else        err          <= 1'b1;
              end
              A_WID_L: wid_shadow <= wr_data;
              A_WID_H: begin
                if (wid_ok) pulse_width <= wid_cand;
                else        err         <= 1'b1;
              end
              default: ;  // CNT_L, CNT_H and ID are read-only
            endcase
          end
          default: ;  // IDLE ignores received bytes
        endcase
      end else if (rd_req) begin
        rd_valid <= 1'b1;
        if (state == IDLE) begin
          rd_data <= 8'hFF;
        end else begin
          rd_data <= reg_read(ptr);
          ptr     <= ptr + 3'd1;
          state   <= DATA;
`ifdef PPT_REGS_SNAPSHOT_EN
          if (ptr == A_CNT_L) cnt_snap <= count[15:8];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ppt_reg_bank.sv
// Self-checking bench for ppt_reg_bank. Each read request pushes its expected
// byte into a queue. A monitor pops and compares whenever rd_valid is seen.
// Configuration outputs are checked directly against hand-computed values.
module tb_ppt_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, wr_valid, rd_req;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] count;
  logic        run;
  logic [15:0] pulse_period, pulse_width;
  logic        count_clr, err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ppt_reg_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .run          (run),
    .pulse_period (pulse_period),
    .pulse_width  (pulse_width),
    .count_clr    (count_clr),
    .err          (err)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, want);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rd_valid: got rd_data 0x%02h, expected no read", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          miscompares++;
          $display("FAIL rd_data: got 0x%02h, expected 0x%02h", rd_data, e);
        end
      end
    end
  end

  // Every stimulus cycle is driven from one negedge to the next, so the
  // posedge in between samples it and outputs are stable when the task returns.
  task automatic cyc(input logic s, input logic p, input logic w, input logic [7:0] d,
                     input logic r);
    @(negedge clk);
    start = s; stop = p; wr_valid = w; wr_data = d; rd_req = r;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
  endtask

  task automatic do_start();           cyc(1, 0, 0, 8'h00, 0); endtask
  task automatic do_stop();            cyc(0, 1, 0, 8'h00, 0); endtask
  task automatic wr(input logic [7:0] d); cyc(0, 0, 1, d, 0); endtask
  task automatic rd(input logic [7:0] e);
    exp_q.push_back(e);
    cyc(0, 0, 0, 8'h00, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; wr_valid = 0; wr_data = 0; rd_req = 0;
    count = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_run", run, 0);
    check("rst_period", pulse_period, 16'd10);
    check("rst_width", pulse_width, 16'd2);
    check("rst_count_clr", count_clr, 0);
    check("rst_err", err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // ID read: set ptr=7, then a fresh transaction reads it.
    do_start(); wr(8'h07); do_stop();
    do_start(); rd(8'hA5);
    @(negedge clk);
    check("rd_valid_one_cycle", rd_valid, 0);

    // Period 32, width 5.
    do_stop(); do_start(); wr(8'h01); wr(8'h20);
    check("period_before_commit", pulse_period, 16'd10);
    wr(8'h00);
    check("period_commit", pulse_period, 16'd32);
    wr(8'h05); wr(8'h00);
    check("width_commit", pulse_width, 16'd5);
    check("err_clean", err, 0);

    // Width 64 >= period 32 is rejected.
    do_stop(); do_start(); wr(8'h03); wr(8'h40); wr(8'h00);
    check("width_rejected", pulse_width, 16'd5);
    check("err_set", err, 1);
    do_stop(); do_start(); wr(8'h00); wr(8'h80);
    check("err_cleared", err, 0);

    // CTRL = 0x03: run and a single count_clr pulse.
    do_stop(); do_start(); wr(8'h00); wr(8'h03);
    check("run_set", run, 1);
    check("count_clr_high", count_clr, 1);
    @(negedge clk);
    check("count_clr_low", count_clr, 0);

    // Burst read from CTRL: committed values, not the 0x40 width shadow.
    do_stop(); do_start(); wr(8'h00);
    rd(8'h01); rd(8'h20); rd(8'h00); rd(8'h05);

    // Counter read across a carry.
    count = 16'h12FF;
    do_stop(); do_start(); wr(8'h05);
    rd(8'hFF);
    count = 16'h1300;
`ifdef PPT_REGS_SNAPSHOT_EN
    rd(8'h12);
`else
    rd(8'h13);
`endif
    rd(8'hA5);

    // A write and a read in the same cycle: the write wins and no read reply is sent.
    do_stop(); do_start(); wr(8'h01);
    cyc(0, 0, 1, 8'h30, 1);
    check("dropped_read", rd_valid, 0);
    wr(8'h00);
    check("period_48", pulse_period, 16'd48);

    // A START and a byte in the same cycle drop the byte and enter ADDR. Then a
    // write of ptr=7 and a data byte wrap ptr to CTRL.
    cyc(1, 0, 1, 8'h06, 0);
    wr(8'h07); wr(8'h11);
    rd(8'h01);

    // A read in IDLE returns 0xFF.
    do_stop(); rd(8'hFF);

    // A reset mid-transaction discards the partial width shadow.
    do_start(); wr(8'h03); wr(8'h77);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("midrst_width", pulse_width, 16'd2);
    check("midrst_period", pulse_period, 16'd10);
    check("midrst_run", run, 0);
    do_start(); wr(8'h04); wr(8'h00);
    check("shadow_discarded", pulse_width, 16'd0);

    repeat (3) @(negedge clk);
    check("reads_outstanding", 16'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppt_reg_bank.md
# ppt_reg_bank

- Byte-level register file between the I2C slave and the pulse generator / pulse counter.
- Decodes address and data bytes delivered by the I2C slave (already synchronised into the `clk` domain).
- Drives `run`, `pulse_period` and `pulse_width`, emits a count-clear strobe and returns read-back bytes, including the live pulse count.
- Replaces the hard-wired period/width/run constants at the top level.

## Interface
Parameters:
- `RST_PERIOD`, 16'd10: reset value of `pulse_period`.
- `RST_WIDTH`, 16'd2: reset value of `pulse_width`.
- `ID_VALUE`, 8'hA5: read-only ID register contents.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: block clock (divided clock domain).
- `rst_n` input 1: synchronous active-low reset.
- `start` input 1: one-cycle strobe, I2C START or repeated START addressed to this slave.
- `stop` input 1: one-cycle strobe, I2C STOP.
- `wr_valid` input 1: one-cycle strobe, `wr_data` holds a received byte.
- `wr_data` input 8: received byte.
- `rd_req` input 1: one-cycle strobe, slave needs the next byte to transmit.
- `rd_data` output 8: read byte, registered.
- `rd_valid` output 1: one-cycle strobe, `rd_data` valid.
- `count` input 16: pulse counter value.
- `run` output 1: pulse generator/counter enable.
- `pulse_period` output 16: committed period.
- `pulse_width` output 16: committed width.
- `count_clr` output 1: one-cycle strobe clearing the pulse counter.
- `err` output 1: sticky, a rejected width/period commit occurred.

## Operation
Register map (pointer `ptr`, 3 bits):
- 0 CTRL: bit0 `run` (RW); bit1 clear (write-1 pulses `count_clr`, reads 0); bit7 `err` (reads sticky flag, write-1 clears it); other bits read 0.
- 1 PER_L, 2 PER_H, 3 WID_L, 4 WID_H: RW.
- 5 CNT_L, 6 CNT_H: RO.
- 7 ID: RO, returns `ID_VALUE`.
- Writes to RO registers are ignored, but `ptr` still increments.

State machine: IDLE, ADDR, DATA.
- IDLE: `wr_valid` ignored. `rd_req` returns 0xFF with `rd_valid` and does not change `ptr`. `start` -> ADDR.
- ADDR: `wr_valid` loads `ptr <= wr_data[2:0]` -> DATA; `wr_data[7:3]` are ignored. `rd_req` reads at the current `ptr`, then increments it -> DATA.
- DATA: `wr_valid` writes at `ptr`, then `ptr+1`. `rd_req` reads at `ptr`, then `ptr+1`.
- `ptr` wraps 7 -> 0.
- From any state: `start` -> ADDR and `stop` -> IDLE. `ptr` is retained across transactions.

16-bit writes:
- Writing PER_L or WID_L loads a low shadow byte only.
- Writing PER_H or WID_H commits `{wr_data, shadow}` atomically.
- A commit is rejected when the candidate period is 0, or when the resulting width is >= the resulting period. On rejection: outputs unchanged, `err` set, shadow kept.
- Reading PER_L, PER_H, WID_L or WID_H returns the committed value, not the shadow.

Priority and boundaries:
- `start`/`stop` beat `wr_valid`/`rd_req` in the same cycle, which are then dropped.
- `wr_valid` beats `rd_req`; the dropped read produces no `rd_valid`.
- CTRL write with bit1 = 1 and bit0 = 0 both stops `run` and pulses `count_clr` in the same cycle.
- A CTRL write of bit7 = 1 in the same cycle as a rejected commit cannot occur, because there is a single write port.

## Timing
- Reset values:
  - `run` = 0, `pulse_period` = `RST_PERIOD`, `pulse_width` = `RST_WIDTH`.
  - `count_clr` = 0, `err` = 0, `rd_valid` = 0, `rd_data` = 0x00.
  - state = IDLE, `ptr` = 0, shadows = 0.
- Write latency: register outputs update on the edge sampling `wr_valid`, visible the next cycle. `count_clr` is high for exactly that one cycle.
- Read latency: `rd_data` and `rd_valid` are valid the cycle after `rd_req`.
- Input strobes may arrive back-to-back; each is processed in its own cycle.
- Reset asserted mid-transaction returns the block to reset values at the next edge; partial shadows are discarded.

## Configuration
- `PPT_REGS_SNAPSHOT_EN` defined: reading CNT_L also latches `count[15:8]` into a snapshot register; a later CNT_H read returns the snapshot. The snapshot resets to 0.
- Not defined: CNT_H returns the live `count[15:8]` at the time of the read.

## Test plan
- Reset, then `start`, addr 0x07, `stop`; `start`, `rd_req` -> `rd_data` = 0xA5 one cycle later, `rd_valid` high one cycle.
- `start`, addr 0x01, data 0x20, 0x00, 0x05, 0x00 -> `pulse_period` = 32 after the 2nd data byte, `pulse_width` = 5 after the 4th; `err` = 0.
- Period 32 committed, then write WID_L = 0x40, WID_H = 0x00 -> width stays 5, `err` = 1; write CTRL = 0x80 -> `err` = 0.
- Write CTRL = 0x03 -> `run` = 1 and `count_clr` high exactly one cycle; CTRL read -> 0x01.
- `count` = 0x12FF, read CNT_L, change `count` to 0x1300, read CNT_H -> with `PPT_REGS_SNAPSHOT_EN` returns 0x12, without it returns 0x13.
- `wr_valid` and `rd_req` in the same cycle -> write applied, no `rd_valid`. Then `start` with `wr_valid` in one cycle -> byte dropped, state ADDR. `ptr` at 7 then one data byte -> `ptr` wraps to 0.
